// File: rtl/pcm_frame_sched.sv
// pcm_frame_sched: snapshots all CIC channel outputs on each en_pcm strobe and
// issues the enabled channels, lowest index first, over a valid/ready
// handshake to one shared consumer. Frames arriving while a previous frame is
// still draining are dropped and raise a sticky overrun flag.
module pcm_frame_sched #(
    parameter int unsigned NCH = 16,
    parameter int unsigned W   = 16,
    parameter int unsigned CW  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_pcm,
    input  logic [NCH*W-1:0] ch_val,
    input  logic [NCH-1:0]   ch_mask,
    output logic [W-1:0]     out_data,
    output logic [CW-1:0]    out_chan,
    output logic             out_first,
    output logic [7:0]       out_seq,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             overrun,
    input  logic             overrun_clr
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_SEND
    } state_t;

    state_t          state_q;
    logic [W-1:0]    frame_buf_q [NCH];
    logic [NCH-1:0]  mask_q;
    logic [CW-1:0]   idx_q;
    logic            first_pending_q;
    logic [7:0]      frame_cnt_q;
    logic [7:0]      frame_seq_q;
    logic [W-1:0]    out_data_q;
    logic [CW-1:0]   out_chan_q;
    logic            out_first_q;
    logic [7:0]      out_seq_q;
    logic            out_valid_q;
    logic            overrun_q;
    logic            overrun_d;
    logic            idx_last;

    assign idx_last = (idx_q == CW'(NCH - 1));

    // Sticky overrun: a drop in the same cycle as a clear keeps the flag set.
    always_comb begin
        overrun_d = overrun_q;
        if (overrun_clr) begin
            overrun_d = 1'b0;
        end
        if (en_pcm && (state_q != S_IDLE)) begin
            overrun_d = 1'b1;
        end
    end

    // Frame capture, channel scan and output handshake state machine.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_IDLE;
            for (int unsigned k = 0; k < NCH; k++) begin
                frame_buf_q[k] <= '0;
            end
            mask_q          <= '0;
            idx_q           <= '0;
            first_pending_q <= 1'b0;
            frame_cnt_q     <= '0;
            frame_seq_q     <= '0;
            out_data_q      <= '0;
            out_chan_q      <= '0;
            out_first_q     <= 1'b0;
            out_seq_q       <= '0;
            out_valid_q     <= 1'b0;
            overrun_q       <= 1'b0;
        end else begin
            overrun_q <= overrun_d;
            case (state_q)
                S_IDLE: begin
                    if (en_pcm) begin
                        for (int unsigned k = 0; k < NCH; k++) begin
                            frame_buf_q[k] <= ch_val[k*W +: W];
                        end
                        mask_q          <= ch_mask;
                        idx_q           <= '0;
                        first_pending_q <= 1'b1;
                        frame_seq_q     <= frame_cnt_q;
                        frame_cnt_q     <= frame_cnt_q + 8'd1;
                        state_q         <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (mask_q[idx_q]) begin
                        out_data_q      <= frame_buf_q[idx_q];
                        out_chan_q      <= idx_q;
                        out_first_q     <= first_pending_q;
                        out_seq_q       <= frame_seq_q;
                        out_valid_q     <= 1'b1;
                        first_pending_q <= 1'b0;
                        state_q         <= S_SEND;
                    end else if (idx_last) begin
                        state_q <= S_IDLE;
                    end else begin
                        idx_q <= idx_q + CW'(1);
                    end
                end
                S_SEND: begin
                    if (out_valid_q && out_ready) begin
                        out_valid_q <= 1'b0;
                        if (idx_last) begin
                            state_q <= S_IDLE;
                        end else begin
                            idx_q   <= idx_q + CW'(1);
                            state_q <= S_SCAN;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;
    assign out_first = out_first_q;
    assign out_seq   = out_seq_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q != S_IDLE);
    assign overrun   = overrun_q;

endmodule

// File: doc/pcm_frame_sched.md
Name: pcm_frame_sched

Overview:
Scheduler that sits between the bank of CIC decimator outputs and a single shared downstream consumer (serialiser, UART or I2S transmitter). On each en_pcm strobe it snapshots all channel values as one frame, then issues the enabled channels one at a time in ascending index order over a valid/ready handshake. Frames that arrive while a previous frame is still draining are dropped and flagged.

Parameters:
NCH, 16, number of CIC channels (power of two, 2..16)
W, 16, sample width per channel
CW, 4, channel index width, equal to log2(NCH)

Ports:
clk  input  1  system clock; the only clock
reset  input  1  synchronous, active-high reset
en_pcm  input  1  one-cycle frame strobe from audio_clock
ch_val  input  NCH*W  flattened channel samples; channel k is bits [k*W+W-1 : k*W]
ch_mask  input  NCH  per-channel enable; sampled together with the frame
out_data  output  W  sample being offered
out_chan  output  CW  channel index of out_data
out_first  output  1  high on the first word issued for a frame
out_seq  output  8  frame sequence number of the current word
out_valid  output  1  word offered
out_ready  input  1  consumer accepts the word
busy  output  1  high whenever state is not IDLE
overrun  output  1  sticky flag: a frame was dropped
overrun_clr  input  1  clears overrun

Behaviour:
- Reset is synchronous and active-high, and all registers are in the clk domain.
- Reset values: state=IDLE, out_valid=0, out_data=0, out_chan=0, out_first=0, out_seq=0, busy=0, overrun=0, internal frame counter=0, idx=0.
- Reset asserted mid-frame discards the buffered frame immediately. Reset overrides all other inputs.
- State IDLE:
  - On en_pcm=1: latch ch_val into the frame buffer and ch_mask into the mask register.
  - Set idx=0 and first_pending=1, capture the frame counter as frame_seq, increment the frame counter (mod 256), then go to SCAN.
- State SCAN: examines one channel per cycle, mask[idx].
  - If mask[idx]=1: load out_data=buf[idx], out_chan=idx, out_first=first_pending, out_seq=frame_seq, out_valid=1; clear first_pending; go to SEND.
  - Else, if idx=NCH-1: go to IDLE.
  - Else: idx=idx+1 and stay in SCAN.
- State SEND: out_data, out_chan, out_first and out_seq hold stable while out_valid=1 and out_ready=0.
  - On out_valid and out_ready: out_valid=0 next cycle.
  - After the handshake, if idx=NCH-1 go to IDLE; otherwise idx=idx+1 and go to SCAN.
  - out_ready is ignored while out_valid=0.
- Latency:
  - en_pcm at cycle t, with ch0 enabled, gives out_valid=1 at cycle t+2.
  - With out_ready held at 1, each enabled channel costs 2 cycles (SCAN plus SEND), and each disabled channel costs 1 cycle.
- Overrun:
  - en_pcm while state is not IDLE drops that frame. The buffer and mask are unchanged and the frame counter does not increment. overrun=1 next cycle.
  - This includes en_pcm in the same cycle as the final handshake. A frame is accepted only in IDLE.
  - overrun_clr=1 clears overrun. If overrun_clr and a drop occur in the same cycle, set wins.
- All-zero mask: the frame is accepted and the counter increments. Zero words are issued, and the block returns to IDLE after NCH SCAN cycles.
- Changes on ch_val or ch_mask after the snapshot have no effect on the frame in flight.
- busy is 1 in SCAN and SEND, and 0 in IDLE.

Test Plan:
1. NCH=16, mask=0xFFFF, ch_val[k]=0x1000+k, out_ready=1, one en_pcm → 16 words, chan 0..15, data 0x1000..0x100F; out_first=1 only on chan 0; out_seq=0; first out_valid 2 cycles after en_pcm; busy falls after the last handshake.
2. mask=0x8005, ready=1 → words for chan 0, 2, 15 only, in that order; out_first on chan 0; IDLE reached 16 SCAN cycles plus 3 SEND cycles after en_pcm.
3. Backpressure: out_ready=0 for 5 cycles while out_valid=1 → out_data and out_chan unchanged across all 5 cycles; the word is accepted exactly once when ready=1.
4. Second en_pcm while draining, with ch_val changed to 0xFFFF → overrun=1; the in-flight frame completes with the original data; the next accepted frame carries out_seq=1, not 2.
5. Sticky overrun: a drop and overrun_clr in the same cycle → overrun stays 1; overrun_clr alone next cycle → overrun becomes 0.
6. mask=0x0000 → no out_valid; busy high for 16 cycles; the next frame carries out_seq incremented. Also: reset asserted in SEND → out_valid=0, busy=0 and out_seq=0 next cycle, and the following frame starts from chan 0.
